recovery_phase_controller: RTL
==============================

RECOVERY_PHASE_CONTROLLER -- requirements
Module: recovery_phase_controller

Interface
REQ-001 The block SHALL have parameter COMMIT_WIDTH, default 2, the maximum number of active-list entries flushed per cycle.
REQ-002 The block SHALL have parameter AL_COUNT_WIDTH, default 7, the width of the active-list occupancy count.
REQ-003 The block SHALL have parameter REFETCH_TYPE_WIDTH, default 3, the width of the refetch-type encoding.
REQ-004 The block SHALL have parameter EXEC_STATE_WIDTH, default 4, the width of the execution-state (cause) encoding.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with the following ports:
- clk  in  1  single clock
- rst  in  1  reset; asynchronous, active-low
- exceptionDetectedInCommitStage  in  1  recovery request from commit
- refetchTypeFromCommitStage  in  REFETCH_TYPE_WIDTH  refetch type of the commit request
- recoveryCauseFromCommitStage  in  EXEC_STATE_WIDTH  cause of the commit request
- exceptionDetectedInExecStage  in  1  branch-mispredict request from execute
- refetchTypeFromExecStage  in  REFETCH_TYPE_WIDTH  refetch type of the execute request
- activeListValidCount  in  AL_COUNT_WIDTH  active-list entries to flush, sampled on accept
- storeCommitterBusy  in  1  committed stores still draining
- phase  out  2  0=COMMIT, 1=RECOVER_0, 2=RECOVER_1
- unableToStartRecovery  out  1  request cannot be accepted this cycle
- toRecoveryPhase  out  1  one-cycle pulse marking recovery entry
- flushNum  out  $clog2(COMMIT_WIDTH)+1  entries flushed this cycle
- recoveryRefetchType  out  REFETCH_TYPE_WIDTH  latched refetch type
- recoveryCause  out  EXEC_STATE_WIDTH  latched cause; 0 for execute requests
- recoveredFromCommit  out  1  latched source; 1 = commit request

Function
REQ-006 The FSM SHALL have exactly three states: COMMIT, RECOVER_0 and RECOVER_1.
REQ-007 unableToStartRecovery SHALL be combinational and equal to (phase != COMMIT) || storeCommitterBusy.
REQ-008 A commit request SHALL be accepted in any cycle in which phase==COMMIT, exceptionDetectedInCommitStage==1 and unableToStartRecovery==0.
REQ-009 An execute request SHALL be accepted in any cycle in which phase==COMMIT, exceptionDetectedInExecStage==1 and unableToStartRecovery==0.
REQ-010 When both requests are acceptable in the same cycle, the commit request SHALL win, because it is older; the execute request SHALL be dropped.
REQ-011 On accept, the block SHALL register, for the next cycle:
- phase<=RECOVER_0
- recoveryRefetchType, recoveryCause and recoveredFromCommit from the winning source
- remaining<=activeListValidCount
REQ-012 toRecoveryPhase SHALL be 1 only during the first cycle of each RECOVER_0 residency.
REQ-013 In RECOVER_0, flushNum SHALL be combinational and equal to min(remaining, COMMIT_WIDTH).
REQ-014 In RECOVER_0, remaining SHALL be decremented by flushNum every cycle, with no underflow.
REQ-015 RECOVER_0 SHALL transition to RECOVER_1 in the cycle in which remaining<=COMMIT_WIDTH, including remaining==0, which gives a single RECOVER_0 cycle with flushNum=0.
REQ-016 RECOVER_1 SHALL last exactly one cycle with flushNum=0 and SHALL then return to COMMIT.
REQ-017 In phase COMMIT, flushNum SHALL be 0.
REQ-018 Requests arriving in RECOVER_0 or RECOVER_1 SHALL be ignored and not queued; the sources re-present them.
REQ-019 The latched outputs (recoveryRefetchType, recoveryCause, recoveredFromCommit) SHALL hold their values until the next accept.
REQ-020 With activeListValidCount=N, the recovery sequence SHALL last ceil(N/COMMIT_WIDTH) RECOVER_0 cycles (minimum 1) plus one RECOVER_1 cycle.
REQ-021 No combinational path SHALL exist from the request inputs to phase, toRecoveryPhase or flushNum.

Reset
REQ-022 When rst==0, the block SHALL asynchronously set:
- phase=COMMIT
- remaining=0, toRecoveryPhase=0, flushNum=0
- recoveryRefetchType=0, recoveryCause=0, recoveredFromCommit=0
REQ-023 Reset asserted mid-recovery SHALL abort the sequence immediately, with no further flush cycles.
REQ-024 On the first clk edge after reset is released, the block SHALL be able to accept a request.

Verification (COMMIT_WIDTH=2)
REQ-025 Reset: assert rst=0 -> phase=0, unableToStartRecovery=0 (storeCommitterBusy=0), all other outputs 0.
REQ-026 Commit request with count=5, refetch=3, cause=7 -> following cycles:
- t+1: phase=1, toRecoveryPhase=1, flushNum=2
- t+2: flushNum=2
- t+3: flushNum=1
- t+4: phase=2, flushNum=0
- t+5: phase=0
- recoveryRefetchType=3, recoveryCause=7 throughout.
REQ-027 storeCommitterBusy=1 with commit request held for 3 cycles -> unableToStartRecovery=1 and phase stays 0; busy drops -> accept on that cycle, phase=1 next cycle.
REQ-028 Commit request (refetch=2) and execute request (refetch=5) in the same cycle -> recoveryRefetchType=2, recoveredFromCommit=1; exec request repeated during RECOVER_0 -> ignored.
REQ-029 Request with count=0 -> one RECOVER_0 cycle (flushNum=0, toRecoveryPhase=1), one RECOVER_1 cycle, then COMMIT.
REQ-030 rst=0 during the second RECOVER_0 cycle of a count=6 sequence -> phase=0 and flushNum=0 immediately; after release, a new request with count=1 completes normally.

Source files
------------

// File: rtl/recovery_phase_controller.sv
// Recovery phase sequencer: accepts a commit- or execute-stage recovery request,
// flushes the active list COMMIT_WIDTH entries per cycle, then returns to COMMIT.
module recovery_phase_controller #(
    parameter int COMMIT_WIDTH       = 2,
    parameter int AL_COUNT_WIDTH     = 7,
    parameter int REFETCH_TYPE_WIDTH = 3,
    parameter int EXEC_STATE_WIDTH   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                exceptionDetectedInCommitStage,
    input  logic [REFETCH_TYPE_WIDTH-1:0]       refetchTypeFromCommitStage,
    input  logic [EXEC_STATE_WIDTH-1:0]         recoveryCauseFromCommitStage,
    input  logic                                exceptionDetectedInExecStage,
    input  logic [REFETCH_TYPE_WIDTH-1:0]       refetchTypeFromExecStage,
    input  logic [AL_COUNT_WIDTH-1:0]           activeListValidCount,
    input  logic                                storeCommitterBusy,
    output logic [1:0]                          phase,
    output logic                                unableToStartRecovery,
    output logic                                toRecoveryPhase,
    output logic [$clog2(COMMIT_WIDTH):0]       flushNum,
    output logic [REFETCH_TYPE_WIDTH-1:0]       recoveryRefetchType,
    output logic [EXEC_STATE_WIDTH-1:0]         recoveryCause,
    output logic                                recoveredFromCommit
);

    localparam int FLUSH_WIDTH = $clog2(COMMIT_WIDTH) + 1;
    localparam logic [AL_COUNT_WIDTH-1:0] COMMIT_WIDTH_AL = AL_COUNT_WIDTH'(COMMIT_WIDTH);

    typedef enum logic [1:0] {
        COMMIT    = 2'd0,
        RECOVER_0 = 2'd1,
        RECOVER_1 = 2'd2
    } phase_e;

    phase_e                            phase_r;
    phase_e                            phaseNext_s;
    logic [AL_COUNT_WIDTH-1:0]         remaining_r;
    logic [AL_COUNT_WIDTH-1:0]         remainingNext_s;
    logic [AL_COUNT_WIDTH-1:0]         flushCount_s;
    logic                              toRecovery_r;
    logic                              toRecoveryNext_s;
    logic [REFETCH_TYPE_WIDTH-1:0]     refetchType_r;
    logic [REFETCH_TYPE_WIDTH-1:0]     refetchTypeNext_s;
    logic [EXEC_STATE_WIDTH-1:0]       cause_r;
    logic [EXEC_STATE_WIDTH-1:0]       causeNext_s;
    logic                              fromCommit_r;
    logic                              fromCommitNext_s;
    logic                              acceptCommit_s;
    logic                              acceptExec_s;

    function automatic logic [AL_COUNT_WIDTH-1:0] minCommitWidth(
        input logic [AL_COUNT_WIDTH-1:0] count
    );
        if (count > COMMIT_WIDTH_AL) begin
            return COMMIT_WIDTH_AL;
        end else begin
            return count;
        end
    endfunction

    assign unableToStartRecovery = (phase_r != COMMIT) || storeCommitterBusy;
    // The commit request is older than any execute request, so it always wins.
    assign acceptCommit_s = !unableToStartRecovery && exceptionDetectedInCommitStage;
    assign acceptExec_s   = !unableToStartRecovery && !exceptionDetectedInCommitStage
                            && exceptionDetectedInExecStage;

    // Flush amount depends only on registered state, never on the request inputs.
    always_comb begin
        flushCount_s = {AL_COUNT_WIDTH{1'b0}};
        if (phase_r == RECOVER_0) begin
            flushCount_s = minCommitWidth(remaining_r);
        end else begin
            flushCount_s = {AL_COUNT_WIDTH{1'b0}};
        end
    end

    // Next-state and next-register computation for the recovery sequence.
    always_comb begin
        phaseNext_s       = phase_r;
        remainingNext_s   = remaining_r;
        toRecoveryNext_s  = 1'b0;
        refetchTypeNext_s = refetchType_r;
        causeNext_s       = cause_r;
        fromCommitNext_s  = fromCommit_r;
        case (phase_r)
            COMMIT: begin
                if (acceptCommit_s) begin
                    phaseNext_s       = RECOVER_0;
                    remainingNext_s   = activeListValidCount;
                    toRecoveryNext_s  = 1'b1;
                    refetchTypeNext_s = refetchTypeFromCommitStage;
                    causeNext_s       = recoveryCauseFromCommitStage;
                    fromCommitNext_s  = 1'b1;
                end else if (acceptExec_s) begin
                    phaseNext_s       = RECOVER_0;
                    remainingNext_s   = activeListValidCount;
                    toRecoveryNext_s  = 1'b1;
                    refetchTypeNext_s = refetchTypeFromExecStage;
                    causeNext_s       = {EXEC_STATE_WIDTH{1'b0}};
                    fromCommitNext_s  = 1'b0;
                end else begin
                    phaseNext_s = COMMIT;
                end
            end
            RECOVER_0: begin
                remainingNext_s = remaining_r - flushCount_s;
                if (remaining_r <= COMMIT_WIDTH_AL) begin
                    phaseNext_s = RECOVER_1;
                end else begin
                    phaseNext_s = RECOVER_0;
                end
            end
            RECOVER_1: begin
                phaseNext_s = COMMIT;
            end
            default: begin
                phaseNext_s     = COMMIT;
                remainingNext_s = {AL_COUNT_WIDTH{1'b0}};
            end
        endcase
    end

    // State and latched-recovery-info registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r       <= COMMIT;
            remaining_r   <= {AL_COUNT_WIDTH{1'b0}};
            toRecovery_r  <= 1'b0;
            refetchType_r <= {REFETCH_TYPE_WIDTH{1'b0}};
            cause_r       <= {EXEC_STATE_WIDTH{1'b0}};
            fromCommit_r  <= 1'b0;
        end else begin
            phase_r       <= phaseNext_s;
            remaining_r   <= remainingNext_s;
            toRecovery_r  <= toRecoveryNext_s;
            refetchType_r <= refetchTypeNext_s;
            cause_r       <= causeNext_s;
            fromCommit_r  <= fromCommitNext_s;
        end
    end

    assign phase               = phase_r;
    assign toRecoveryPhase     = toRecovery_r;
    assign flushNum            = FLUSH_WIDTH'(flushCount_s);
    assign recoveryRefetchType = refetchType_r;
    assign recoveryCause       = cause_r;
    assign recoveredFromCommit = fromCommit_r;

endmodule
